fact_arbiter: RTL and testbench

Shares one factorial engine (go/n in, done/err/result out) between two independent requesters: port 0 is the CPU-side memory-mapped factorial register block, port 1 is a second master. The block arbitrates round-robin, latches the winner's operand, sequences the engine through one job and returns the result with a one-cycle done pulse. It sits between the requesters and the engine, and the engine is otherwise unmodified.

---
 rtl/fact_arb_pkg.sv | 19 +
 rtl/fact_arbiter_rr_pick2.sv | 25 ++
 rtl/fact_arbiter.sv | 144 ++++++++++++++
 tb/tb_fact_arbiter.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fact_arb_pkg.sv
// fact_arb_pkg: shared definitions for the factorial-engine arbiter.
//   state_t     : arbiter FSM state encoding (IDLE, START, BUSY, RESP)
//   NW_DEF      : default operand width
//   DW_DEF      : default result width
//   FACT_MAX_N  : largest operand whose factorial fits in 32 bits
package fact_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int NW_DEF     = 4;
  localparam int DW_DEF     = 32;
  localparam int FACT_MAX_N = 12;

endpackage

// File: rtl/fact_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker.
//   req0, req1 : request levels
//   last       : port that owned the resource most recently
//   valid      : at least one request present
//   winner     : chosen port (0 or 1); meaningful only when valid
module rr_pick2
  import fact_arb_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = req0 | req1;
    winner = req1;
    // On a tie the port that did not go last wins, so neither can starve.
    if (req0 && req1) begin
      winner = ~last;
    end
  end

endmodule

// File: rtl/fact_arbiter.sv
// fact_arbiter: shares one factorial engine between two requesters.
//   Clk, Rst            : clock (rising edge), asynchronous active-high reset
//   req0/1, n0/1        : request level and operand per port
//   gnt0/1              : port owns the engine (START..RESP)
//   done0/1             : one-cycle completion pulse per port
//   err0/1, result0/1   : per-port status/result, held until that port's next done
//   eng_go, eng_n       : start pulse and latched operand to the engine
//   eng_done, eng_err, eng_result : engine completion and its outputs
//   busy                : arbiter is not IDLE
// Optional build macro FACT_ARB_TIMEOUT_EN adds a BUSY watchdog of TIMEOUT
// cycles that aborts the job with err=1, result=0.
module fact_arbiter
  import fact_arb_pkg::*;
#(
  parameter int NW      = NW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 64
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic          req0,
  input  logic [NW-1:0] n0,
  output logic          gnt0,
  output logic          done0,
  output logic          err0,
  output logic [DW-1:0] result0,
  input  logic          req1,
  input  logic [NW-1:0] n1,
  output logic          gnt1,
  output logic          done1,
  output logic          err1,
  output logic [DW-1:0] result1,
  output logic          eng_go,
  output logic [NW-1:0] eng_n,
  input  logic          eng_done,
  input  logic          eng_err,
  input  logic [DW-1:0] eng_result,
  output logic          busy
);

  state_t state, state_next;
  logic   owner;
  logic   last;
  logic   pick_valid, pick_winner;
  logic   cap_job, cap_resp, abort;

  rr_pick2 u_pick (
    .req0   (req0),
    .req1   (req1),
    .last   (last),
    .valid  (pick_valid),
    .winner (pick_winner)
  );

`ifdef FACT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wd_cnt;
  logic          wd_hit;

  // Held at zero outside BUSY, so it starts from zero on every BUSY entry.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wd_cnt <= '0;
    end else if (state != BUSY) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + CW'(1);
    end
  end

  assign wd_hit = (wd_cnt == CW'(TIMEOUT - 1));
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT > 0);
`endif

  always_comb begin
    state_next = state;
    cap_job    = 1'b0;
    cap_resp   = 1'b0;
    abort      = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = START;
          cap_job    = 1'b1;
        end
      end
      START: state_next = BUSY;
      BUSY: begin
        // eng_done outside BUSY is ignored simply by not looking at it.
        if (eng_done) begin
          state_next = RESP;
          cap_resp   = 1'b1;
        end
`ifdef FACT_ARB_TIMEOUT_EN
        else if (wd_hit) begin
          state_next = RESP;
          abort      = 1'b1;
        end
`endif
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state   <= IDLE;
      owner   <= 1'b0;
      last    <= 1'b1;
      eng_n   <= '0;
      result0 <= '0;
      result1 <= '0;
      err0    <= 1'b0;
      err1    <= 1'b0;
    end else begin
      state <= state_next;
      if (cap_job) begin
        owner <= pick_winner;
        last  <= pick_winner;
        eng_n <= pick_winner ? n1 : n0;
      end
      if (cap_resp || abort) begin
        if (owner) begin
          result1 <= cap_resp ? eng_result : '0;
          err1    <= abort | eng_err;
        end else begin
          result0 <= cap_resp ? eng_result : '0;
          err0    <= abort | eng_err;
        end
      end
    end
  end

  assign busy   = (state != IDLE);
  assign eng_go = (state == START);
  assign gnt0   = busy & ~owner;
  assign gnt1   = busy & owner;
  assign done0  = (state == RESP) & ~owner;
  assign done1  = (state == RESP) & owner;

endmodule

// File: tb/tb_fact_arbiter.sv
`timescale 1ns/1ps
module tb_fact_arbiter;
  import fact_arb_pkg::*;

  localparam int NW  = 4;
  localparam int DW  = 32;
  localparam int TO  = 64;
  localparam int LAT = 5;
`ifdef FACT_ARB_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif
  localparam int VW = 6 + NW + 2 * DW + 2;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [NW-1:0] n0 = '0, n1 = '0;
  logic          gnt0, done0, err0, gnt1, done1, err1, eng_go, busy;
  logic [DW-1:0] result0, result1;
  logic [NW-1:0] eng_n;
  logic          eng_done = 1'b0, eng_err = 1'b0;
  logic [DW-1:0] eng_result = '0;

  fact_arbiter #(.NW(NW), .DW(DW), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .req0(req0), .n0(n0), .gnt0(gnt0), .done0(done0), .err0(err0), .result0(result0),
    .req1(req1), .n1(n1), .gnt1(gnt1), .done1(done1), .err1(err1), .result1(result1),
    .eng_go(eng_go), .eng_n(eng_n), .eng_done(eng_done), .eng_err(eng_err),
    .eng_result(eng_result), .busy(busy)
  );

  always #5 Clk = ~Clk;

  function automatic logic [DW-1:0] fact(input int n);
    logic [DW-1:0] r;
    r = 1;
    for (int i = 2; i <= n; i++) r = r * DW'(i);
    return r;
  endfunction

  // Engine model: fixed latency, error above FACT_MAX_N, optional stall,
  // and a one-shot injected (late) completion.
  bit            stall = 1'b0, inject = 1'b0;
  int            e_cnt = 0;
  logic [NW-1:0] e_n = '0;
  always @(negedge Clk) begin
    if (Rst) begin
      e_cnt = 0; eng_done = 1'b0; eng_err = 1'b0; eng_result = '0;
    end else begin
      eng_done = 1'b0;
      if (inject) begin
        eng_done = 1'b1; eng_err = 1'b0; eng_result = 32'hDEADBEEF;
      end else if (eng_go) begin
        e_n = eng_n; e_cnt = LAT;
      end else if (e_cnt > 0) begin
        e_cnt--;
        if (e_cnt == 0 && !stall) begin
          eng_done   = 1'b1;
          eng_err    = (int'(e_n) > FACT_MAX_N);
          eng_result = eng_err ? '0 : fact(int'(e_n));
        end
      end
    end
  end

  // Job-schedule model: a granted job is one go cycle, blen busy cycles,
  // one response cycle, then idle.
  int            s = 0, blen = LAT;
  bit            m_owner = 1'b0, m_last = 1'b1, m_abort = 1'b0;
  logic [NW-1:0] m_n = '0;
  logic [DW-1:0] m_res [2] = '{'0, '0};
  bit            m_err [2] = '{1'b0, 1'b0};
  always @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      s = 0; m_owner = 1'b0; m_last = 1'b1; m_n = '0;
      m_res[0] = '0; m_res[1] = '0; m_err[0] = 1'b0; m_err[1] = 1'b0;
    end else if (s == 0) begin
      if (req0 || req1) begin
        if (req0 && req1) m_owner = (m_last == 1'b0);
        else              m_owner = req1;
        m_last  = m_owner;
        m_n     = m_owner ? n1 : n0;
        m_abort = stall && TEN;
        blen    = stall ? (TEN ? TO : 1 << 30) : LAT;
        s       = 1;
      end
    end else if (s == blen + 1) begin
      s = s + 1;
      m_err[m_owner] = m_abort || (int'(m_n) > FACT_MAX_N);
      m_res[m_owner] = m_err[m_owner] ? '0 : fact(int'(m_n));
    end else if (s == blen + 2) begin
      s = 0;
    end else begin
      s = s + 1;
    end
  end

  int n_vec = 0, n_bad = 0;
  int cnt_done0 = 0, cnt_done1 = 0;
  bit saw1 = 1'b0;

  task automatic cycle_check();
    logic [VW-1:0] got, want;
    bit            ed;
    ed   = (s != 0) && (s == blen + 2);
    got  = {gnt0, gnt1, done0, done1, eng_go, busy, eng_n, result0, err0, result1, err1};
    want = {(s != 0) && !m_owner, (s != 0) && m_owner, ed && !m_owner, ed && m_owner,
            s == 1, s != 0, m_n, m_res[0], m_err[0], m_res[1], m_err[1]};
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL cycle t=%0t: got %h want %h (gnt/done/go/busy/eng_n/r0/e0/r1/e1)", $time, got, want);
    end
    if (ed) $display("txn port%0d n=%0d result=%h err=%b", m_owner, m_n, m_res[m_owner], m_err[m_owner]);
    if (done0 === 1'b1) cnt_done0++;
    if (done1 === 1'b1) cnt_done1++;
    if (gnt1 === 1'b1 || done1 === 1'b1) saw1 = 1'b1;
  endtask

  task automatic step(input int k = 1);
    for (int i = 0; i < k; i++) begin
      @(posedge Clk); #1; cycle_check(); #1;
    end
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Waits for eng_go (sel=0), done0 (1), done1 (2) or either done (3).
  task automatic wait_ev(input int sel, input int budget, output int cyc);
    bit hit;
    hit = 1'b0; cyc = 0;
    for (int i = 0; i < budget && !hit; i++) begin
      step();
      cyc = i + 1;
      case (sel)
        0: hit = (eng_go === 1'b1);
        1: hit = (done0 === 1'b1);
        2: hit = (done1 === 1'b1);
        default: hit = (done0 === 1'b1) || (done1 === 1'b1);
      endcase
    end
    n_vec++;
    if (!hit) begin
      n_bad++;
      $display("FAIL wait_ev%0d: no event within %0d cycles (got none, want one)", sel, budget);
    end
  endtask

  task automatic reset_dut();
    Rst = 1'b1; step(2); Rst = 1'b0; step();
  endtask

  int cyc, d0;
  int exp_port [4] = '{0, 1, 0, 1};

  initial begin
    step(3);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_gnt", 32'({gnt0, gnt1, done0, done1, eng_go}), 32'd0);
    chk("reset_result", result0 | result1, 32'd0);
    Rst = 1'b0;
    step(2);

    // Single request from port 0.
    req0 = 1'b1; n0 = 4'd5;
    wait_ev(0, 10, cyc);
    chk("t1_go_latency", 32'(cyc), 32'd1);
    chk("t1_eng_n", 32'(eng_n), 32'd5);
    wait_ev(1, 20, cyc);
    chk("t1_done_latency", 32'(cyc), 32'(LAT + 1));
    chk("t1_result0", result0, 32'h00000078);
    chk("t1_err0", 32'(err0), 32'd0);
    req0 = 1'b0;
    step(3);
    chk("t1_port1_quiet", 32'(saw1), 32'd0);

    // Simultaneous requests held high: grants alternate 0,1,0,1.
    reset_dut();
    req0 = 1'b1; req1 = 1'b1; n0 = 4'd3; n1 = 4'd4;
    for (int i = 0; i < 4; i++) begin
      wait_ev(3, 30, cyc);
      chk("t2_port", 32'(done1), 32'(exp_port[i]));
      if (done1) chk("t2_result1", result1, 32'h18);
      else       chk("t2_result0", result0, 32'h6);
    end
    req0 = 1'b0; req1 = 1'b0;
    step(10);

    // Port 1 alone: largest legal operand, then overflow.
    req1 = 1'b1; n1 = 4'd12;
    wait_ev(2, 20, cyc);
    chk("t3_result1_12", result1, 32'h1C8CFC00);
    chk("t3_err1_12", 32'(err1), 32'd0);
    n1 = 4'd13;
    wait_ev(2, 20, cyc);
    chk("t3_err1_13", 32'(err1), 32'd1);
    chk("t3_result0_held", result0, 32'h6);
    req1 = 1'b0;
    step(3);

    // Request dropped mid-job, operand changed after grant.
    req0 = 1'b1; n0 = 4'd5;
    wait_ev(0, 10, cyc);
    n0 = 4'd9;
    step(2);
    req0 = 1'b0;
    d0 = cnt_done0;
    wait_ev(1, 20, cyc);
    chk("t4_result0", result0, 32'h78);
    step(10);
    chk("t4_one_pulse", 32'(cnt_done0 - d0), 32'd1);

    // Reset in the middle of a job.
    req1 = 1'b1; n1 = 4'd7;
    wait_ev(0, 10, cyc);
    step(2);
    Rst = 1'b1; #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_ctrl", 32'({gnt0, gnt1, done0, done1, eng_go}), 32'd0);
    chk("t5_results", result0 | result1 | 32'(eng_n), 32'd0);
    chk("t5_errs", 32'({err0, err1}), 32'd0);
    req1 = 1'b0;
    d0 = cnt_done1;
    step(2);
    Rst = 1'b0;
    step(10);
    chk("t5_no_done", 32'(cnt_done1 - d0), 32'd0);

    // Stalled engine.
    stall = 1'b1; req0 = 1'b1; n0 = 4'd2;
    wait_ev(0, 10, cyc);
`ifdef FACT_ARB_TIMEOUT_EN
    wait_ev(1, TO + 20, cyc);
    chk("t6_timeout_latency", 32'(cyc), 32'(TO + 1));
    chk("t6_err0", 32'(err0), 32'd1);
    chk("t6_result0", result0, 32'd0);
    req0 = 1'b0; stall = 1'b0;
    d0 = cnt_done0;
    step();
    inject = 1'b1; step(); inject = 1'b0;
    step(5);
    chk("t6_late_ignored", 32'({busy, 4'(cnt_done0 - d0)}), 32'd0);
`else
    d0 = cnt_done0;
    step(200);
    chk("t6_still_busy", 32'({busy, gnt0}), 32'd3);
    chk("t6_no_done", 32'(cnt_done0 - d0), 32'd0);
    req0 = 1'b0; stall = 1'b0;
    reset_dut();
    chk("t6_idle_after_rst", 32'(busy), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
